// File: rtl/seq_detect_param.sv
// ---------------------------------------------------------------------------
// SeqDetectParam: serial pattern detector with a run-time loadable pattern.
//
// One bit (w) is consumed on each rising Clock edge where En=1. The block
// tracks how far the recent input has progressed through the pattern. When
// the final pattern bit arrives it emits a one-cycle registered pulse on z
// and bumps a saturating match counter.
//
// Ports
//   Clock      : sole clock, all state updates on the rising edge
//   Reset      : asynchronous, active-high; restores PAT_INIT and clears all
//   En         : sample enable; w is consumed only when En=1
//   w          : serial data bit
//   Overlap    : 1 = resume from the pattern's longest border after a match,
//                0 = restart from scratch after a match
//   Load       : latch Pattern into the pattern register (beats En)
//   Pattern    : new pattern, MSB is the first bit of the sequence
//   z          : registered match pulse
//   MatchCount : saturating number of matches since reset/load
//   CurState   : current progress k (matched prefix length, 0..PAT_W-1)
// ---------------------------------------------------------------------------
module seq_detect_param #(
  parameter int              PAT_W    = 4,
  parameter int              CNT_W    = 8,
  parameter logic [PAT_W-1:0] PAT_INIT = 4'b1101
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      En,
  input  logic                      w,
  input  logic                      Overlap,
  input  logic                      Load,
  input  logic [PAT_W-1:0]          Pattern,
  output logic                      z,
  output logic [CNT_W-1:0]          MatchCount,
  output logic [$clog2(PAT_W)-1:0]  CurState
);

  localparam int KW = $clog2(PAT_W);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // One spare bit so a mask of all PAT_W ones can be formed as (1<<PAT_W)-1.
  typedef logic [PAT_W:0] ext_t;

  // Mask of the n lowest bits.
  function automatic ext_t low_mask(input int n);
    return (ext_t'(1) << n) - ext_t'(1);
  endfunction

  logic [PAT_W-1:0] pat_reg;
  logic [KW-1:0]    cur_k;
  logic [CNT_W-1:0] match_cnt;
  logic             z_q;

  logic [PAT_W-1:0] pat_nxt;
  logic [KW-1:0]    k_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             z_nxt;

  logic [PAT_W-1:0] pat_rev;
  ext_t             pat_ext;
  ext_t             s_ext;
  logic [KW-1:0]    border;
  int               best;
  logic             match;

  // Reverse the pattern so the first-matched bit sits at index 0. Prefixes
  // then become simple low-bit masks and suffixes become right shifts.
  for (genvar g = 0; g < PAT_W; g++) begin : g_rev
    assign pat_rev[g] = pat_reg[PAT_W-1-g];
  end
  assign pat_ext = ext_t'(pat_rev);

  // Longest proper border of the pattern: the longest prefix shorter than
  // the pattern that also appears as its suffix. This is where progress
  // resumes after an overlapping match.
  always_comb begin
    border = '0;
    for (int j = 1; j < PAT_W; j++) begin
      if (((pat_ext >> (PAT_W - j)) & low_mask(j)) == (pat_ext & low_mask(j)))
        border = KW'(j);
    end
  end

  // Because progress k means "the last k bits equal the first k pattern
  // bits", the relevant history is fully reconstructed from the pattern
  // itself, so no separate shift register is needed. Append w to that
  // prefix and find the longest pattern prefix that ends the new string.
  always_comb begin
    s_ext = (pat_ext & low_mask(int'(cur_k))) | (ext_t'(w) << cur_k);
    best  = 0;
    for (int j = 1; j <= PAT_W; j++) begin
      if (j <= int'(cur_k) + 1) begin
        if (((s_ext >> (int'(cur_k) + 1 - j)) & low_mask(j)) == (pat_ext & low_mask(j)))
          best = j;
      end
    end
    match = (best == PAT_W);
  end

  // Next-state selection. Load wins over En and ignores w; with En low
  // everything holds and z drops. A match either falls back to the border
  // or discards history entirely, depending on Overlap at that edge.
  always_comb begin
    pat_nxt = pat_reg;
    k_nxt   = cur_k;
    cnt_nxt = match_cnt;
    z_nxt   = 1'b0;
    if (Load) begin
      pat_nxt = Pattern;
      k_nxt   = '0;
      cnt_nxt = '0;
    end else if (En) begin
      if (match) begin
        z_nxt = 1'b1;
        if (match_cnt != CNT_MAX)
          cnt_nxt = match_cnt + CNT_W'(1);
        k_nxt = Overlap ? border : '0;
      end else begin
        k_nxt = KW'(best);
      end
    end
  end

  // State register; Reset acts immediately without waiting for a clock.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      pat_reg   <= PAT_INIT;
      cur_k     <= '0;
      match_cnt <= '0;
      z_q       <= 1'b0;
    end else begin
      pat_reg   <= pat_nxt;
      cur_k     <= k_nxt;
      match_cnt <= cnt_nxt;
      z_q       <= z_nxt;
    end
  end

  assign z          = z_q;
  assign MatchCount = match_cnt;
  assign CurState   = cur_k;

endmodule

// File: tb/tb_seq_detect_param.sv
// ---------------------------------------------------------------------------
// Testbench for seq_detect_param. Two instances share all inputs: one with
// an 8-bit counter and one with a 2-bit counter to exercise saturation.
// Stimulus tasks push hand-computed expectations into a queue; a monitor
// pops one entry after every clock edge that consumed a stimulus.
// ---------------------------------------------------------------------------
module tb_seq_detect_param;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       En;
  logic       w;
  logic       Overlap;
  logic       Load;
  logic [3:0] Pattern;

  logic       z;
  logic [7:0] matchCount;
  logic [1:0] curState;
  logic       zSat;
  logic [1:0] satCount;
  logic [1:0] curStateSat;

  typedef struct {
    int z;
    int cnt;
    int k;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  seq_detect_param #(.PAT_W(4), .CNT_W(8), .PAT_INIT(4'b1101)) dut (
    .Clock(Clock), .Reset(Reset), .En(En), .w(w), .Overlap(Overlap),
    .Load(Load), .Pattern(Pattern), .z(z), .MatchCount(matchCount),
    .CurState(curState)
  );

  seq_detect_param #(.PAT_W(4), .CNT_W(2), .PAT_INIT(4'b1101)) dutSat (
    .Clock(Clock), .Reset(Reset), .En(En), .w(w), .Overlap(Overlap),
    .Load(Load), .Pattern(Pattern), .z(zSat), .MatchCount(satCount),
    .CurState(curStateSat)
  );

  always #5 Clock = ~Clock;

  // Single comparison with pass/fail bookkeeping.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs on the falling edge and queue the state
  // expected right after the following rising edge.
  task automatic applyStimulus(input logic en, input logic bitIn, input logic ovl,
                               input logic ld, input logic [3:0] pat,
                               input int expZ, input int expCnt, input int expK);
    @(negedge Clock);
    En      = en;
    w       = bitIn;
    Overlap = ovl;
    Load    = ld;
    Pattern = pat;
    expQ.push_back('{expZ, expCnt, expK});
  endtask

  task automatic sendBit(input logic bitIn, input logic ovl,
                         input int expZ, input int expCnt, input int expK);
    applyStimulus(1'b1, bitIn, ovl, 1'b0, 4'b0000, expZ, expCnt, expK);
  endtask

  // Disabled cycle with w=1 present to show it is ignored.
  task automatic idleCycle(input logic ovl, input int expCnt, input int expK);
    applyStimulus(1'b0, 1'b1, ovl, 1'b0, 4'b0000, 0, expCnt, expK);
  endtask

  // Assert Reset between clock edges and confirm everything clears before
  // the next rising edge arrives.
  task automatic resetDut(input string tag);
    @(negedge Clock);
    #2;
    Reset = 1'b1;
    En    = 1'b0;
    Load  = 1'b0;
    #1;
    checkOutput({tag, "_z"},        int'(z),           0);
    checkOutput({tag, "_cnt"},      int'(matchCount),  0);
    checkOutput({tag, "_k"},        int'(curState),    0);
    checkOutput({tag, "_zSat"},     int'(zSat),        0);
    checkOutput({tag, "_cntSat"},   int'(satCount),    0);
    checkOutput({tag, "_kSat"},     int'(curStateSat), 0);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // Monitor: one expectation per consumed edge, compared 1 time unit later.
  initial begin
    forever begin
      @(posedge Clock);
      #1;
      if (expQ.size() > 0) begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("z",      int'(z),           e.z);
        checkOutput("cnt",    int'(matchCount),  e.cnt);
        checkOutput("k",      int'(curState),    e.k);
        checkOutput("zSat",   int'(zSat),        e.z);
        checkOutput("cntSat", int'(satCount),    (e.cnt > 3) ? 3 : e.cnt);
        checkOutput("kSat",   int'(curStateSat), e.k);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    int waitCycles;

    Reset   = 1'b1;
    En      = 1'b0;
    w       = 1'b0;
    Overlap = 1'b1;
    Load    = 1'b0;
    Pattern = 4'b0000;
    #1;
    checkOutput("init_z",   int'(z),          0);
    checkOutput("init_cnt", int'(matchCount), 0);
    checkOutput("init_k",   int'(curState),   0);
    @(negedge Clock);
    Reset = 1'b0;

    $display("[TB] basic match 1101");
    sendBit(1'b1, 1'b1, 0, 0, 1);
    sendBit(1'b1, 1'b1, 0, 0, 2);
    sendBit(1'b0, 1'b1, 0, 0, 3);
    sendBit(1'b1, 1'b1, 1, 1, 1);
    idleCycle(1'b1, 1, 1);

    $display("[TB] overlap on 1101101");
    resetDut("rstA");
    sendBit(1'b1, 1'b1, 0, 0, 1);
    sendBit(1'b1, 1'b1, 0, 0, 2);
    sendBit(1'b0, 1'b1, 0, 0, 3);
    sendBit(1'b1, 1'b1, 1, 1, 1);
    sendBit(1'b1, 1'b1, 0, 1, 2);
    sendBit(1'b0, 1'b1, 0, 1, 3);
    sendBit(1'b1, 1'b1, 1, 2, 1);

    $display("[TB] non-overlap on 1101101");
    resetDut("rstB");
    sendBit(1'b1, 1'b0, 0, 0, 1);
    sendBit(1'b1, 1'b0, 0, 0, 2);
    sendBit(1'b0, 1'b0, 0, 0, 3);
    sendBit(1'b1, 1'b0, 1, 1, 0);
    sendBit(1'b1, 1'b0, 0, 1, 1);
    sendBit(1'b0, 1'b0, 0, 1, 0);
    sendBit(1'b1, 1'b0, 0, 1, 1);

    $display("[TB] enable gating");
    resetDut("rstC");
    sendBit(1'b1, 1'b1, 0, 0, 1);
    idleCycle(1'b1, 0, 1);
    sendBit(1'b1, 1'b1, 0, 0, 2);
    idleCycle(1'b1, 0, 2);
    sendBit(1'b0, 1'b1, 0, 0, 3);
    idleCycle(1'b1, 0, 3);
    sendBit(1'b1, 1'b1, 1, 1, 1);
    idleCycle(1'b1, 1, 1);

    $display("[TB] load mid-stream");
    resetDut("rstD");
    sendBit(1'b1, 1'b1, 0, 0, 1);
    sendBit(1'b1, 1'b1, 0, 0, 2);
    sendBit(1'b0, 1'b1, 0, 0, 3);
    sendBit(1'b1, 1'b1, 1, 1, 1);
    sendBit(1'b1, 1'b1, 0, 1, 2);
    sendBit(1'b0, 1'b1, 0, 1, 3);
    sendBit(1'b1, 1'b1, 1, 2, 1);
    sendBit(1'b1, 1'b1, 0, 2, 2);
    sendBit(1'b0, 1'b1, 0, 2, 3);
    sendBit(1'b1, 1'b1, 1, 3, 1);
    sendBit(1'b1, 1'b1, 0, 3, 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'b1111, 0, 0, 0);
    sendBit(1'b1, 1'b1, 0, 0, 1);
    sendBit(1'b1, 1'b1, 0, 0, 2);
    sendBit(1'b1, 1'b1, 0, 0, 3);
    sendBit(1'b1, 1'b1, 1, 1, 3);
    sendBit(1'b1, 1'b1, 1, 2, 3);

    $display("[TB] async reset with k=3 and z high, then PAT_INIT restored");
    resetDut("rstE");
    sendBit(1'b1, 1'b1, 0, 0, 1);
    sendBit(1'b1, 1'b1, 0, 0, 2);
    sendBit(1'b0, 1'b1, 0, 0, 3);
    sendBit(1'b1, 1'b1, 1, 1, 1);

    $display("[TB] saturation, five non-overlapping matches");
    resetDut("rstF");
    for (int g = 0; g < 5; g++) begin
      sendBit(1'b1, 1'b0, 0, g, 1);
      sendBit(1'b1, 1'b0, 0, g, 2);
      sendBit(1'b0, 1'b0, 0, g, 3);
      sendBit(1'b1, 1'b0, 1, g + 1, 0);
    end
    idleCycle(1'b0, 5, 0);

    waitCycles = 0;
    while (expQ.size() > 0 && waitCycles < 20) begin
      @(posedge Clock);
      waitCycles++;
    end
    #2;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
